// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared types and constants for the serial carry-lookahead adder
package cla_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int nslice(input int width);
      return width / SLICE_W;
   endfunction

endpackage

`ifndef CLA_WIDTH_CHECK
`define CLA_WIDTH_CHECK(w) \
   if ((((w) % cla_pkg::SLICE_W) != 0) || ((w) < cla_pkg::SLICE_W)) begin : g_width_err \
      $error("cla_serial_adder: WIDTH must be a positive multiple of 4"); \
   end
`endif

// File: rtl/cla_slice4.sv
// rtl/cla_slice4.sv - combinational 4-bit carry-lookahead slice
module cla_slice4 (
   output logic [3:0] sum,
   output logic       cout,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin
);

   logic [3:0] g;
   logic [3:0] p;
   logic       c1;
   logic       c2;
   logic       c3;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is a flat sum of products of g/p and cin, so no ripple inside the slice.
   assign c1   = g[0] | (p[0] & cin);
   assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
   assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
   assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);

   assign sum = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/cla_serial_adder.sv
// rtl/cla_serial_adder.sv - multi-cycle adder running one 4-bit lookahead slice per clock
module cla_serial_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             busy
);

   localparam int NSLICE = nslice(WIDTH);
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

   `CLA_WIDTH_CHECK(WIDTH)

   state_t           state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] merged;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             a_msb;
   logic             b_msb;
   logic [3:0]       slice_sum;
   logic             slice_cout;
   logic             last;

   cla_slice4 u_slice (
      .sum  (slice_sum),
      .cout (slice_cout),
      .a    (a_sh[SLICE_W-1:0]),
      .b    (b_sh[SLICE_W-1:0]),
      .cin  (carry)
   );

   // Result with the current slice already written in, so the final edge can publish it directly.
   always_comb begin
      merged = result;
      for (int k = 0; k < NSLICE; k++) begin
         if (cnt == CNT_W'(k)) begin
            merged[k*SLICE_W +: SLICE_W] = slice_sum;
         end
      end
   end

   assign last      = (cnt == CNT_W'(NSLICE - 1));
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_sh     <= '0;
         b_sh     <= '0;
         result   <= '0;
         carry    <= 1'b0;
         cnt      <= '0;
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         sum      <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  carry  <= cin;
                  cnt    <= '0;
                  result <= '0;
                  a_msb  <= a[WIDTH-1];
                  b_msb  <= b[WIDTH-1];
                  state  <= RUN;
               end
            end
            RUN: begin
               result <= merged;
               carry  <= slice_cout;
               a_sh   <= a_sh >> SLICE_W;
               b_sh   <= b_sh >> SLICE_W;
               cnt    <= cnt + 1'b1;
               // Visible outputs change only here, so they hold across IDLE and the next RUN.
               if (last) begin
                  sum      <= merged;
                  cout     <= slice_cout;
                  overflow <= (a_msb == b_msb) && (merged[WIDTH-1] != a_msb);
                  state    <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cla_serial_adder.sv
// tb/tb_cla_serial_adder.sv - directed self-checking bench for cla_serial_adder
module tb_cla_serial_adder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        cin = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] sum;
   logic        cout;
   logic        overflow;
   logic        busy;

   logic        n_in_valid = 1'b0;
   logic        n_in_ready;
   logic [3:0]  n_a = '0;
   logic [3:0]  n_b = '0;
   logic        n_cin = 1'b0;
   logic        n_out_valid;
   logic        n_out_ready = 1'b0;
   logic [3:0]  n_sum;
   logic        n_cout;
   logic        n_overflow;
   logic        n_busy;

   int tests = 0;
   int fails = 0;
   int lat;

   always #5 clk = ~clk;

   cla_serial_adder #(.WIDTH(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .overflow  (overflow),
      .busy      (busy)
   );

   cla_serial_adder #(.WIDTH(4)) dut4 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (n_in_valid),
      .in_ready  (n_in_ready),
      .a         (n_a),
      .b         (n_b),
      .cin       (n_cin),
      .out_valid (n_out_valid),
      .out_ready (n_out_ready),
      .sum       (n_sum),
      .cout      (n_cout),
      .overflow  (n_overflow),
      .busy      (n_busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
      in_valid = 1'b1;
      a = ta;
      b = tb;
      cin = tc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 16'hDEAD;
      b = 16'hBEEF;
      cin = 1'b1;
   endtask

   task automatic wait_done(output int edges);
      edges = 0;
      while (!out_valid && edges < 20) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic run_and_check(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                                input logic tc, input logic [15:0] es, input logic ec,
                                input logic eo);
      start_op(ta, tb, tc);
      wait_done(lat);
      check({tag, " latency"}, 32'(lat), 32'd4);
      check({tag, " sum"}, 32'(sum), 32'(es));
      check({tag, " cout"}, 32'(cout), 32'(ec));
      check({tag, " overflow"}, 32'(overflow), 32'(eo));
      take();
      check({tag, " idle after take"}, 32'({in_ready, out_valid, busy}), 32'b100);
   endtask

   initial begin
      #12;
      check("reset flags", 32'({in_ready, out_valid, busy}), 32'b100);
      check("reset sum", 32'(sum), 32'h0);
      check("reset cout/ovf", 32'({cout, overflow}), 32'b00);
      check("reset w4 flags", 32'({n_in_ready, n_out_valid, n_busy}), 32'b100);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic add with latency tracked edge by edge
      start_op(16'h0001, 16'h0002, 1'b0);
      check("t1 running", 32'({in_ready, out_valid, busy}), 32'b001);
      wait_done(lat);
      check("t1 latency", 32'(lat), 32'd4);
      check("t1 sum", 32'(sum), 32'h0003);
      check("t1 cout/ovf", 32'({cout, overflow}), 32'b00);
      take();
      check("t1 idle", 32'({in_ready, out_valid, busy}), 32'b100);

      run_and_check("t2 carry chain", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
      run_and_check("t3 pos ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_and_check("t3 neg ovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

      // Backpressure with new operands offered during DONE
      start_op(16'h0010, 16'h0020, 1'b0);
      wait_done(lat);
      check("t4 sum", 32'(sum), 32'h0030);
      in_valid = 1'b1;
      a = 16'h1111;
      b = 16'h2222;
      cin = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("t4 hold", 32'({out_valid, in_ready, sum}), 32'({1'b1, 1'b0, 16'h0030}));
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("t4 no accept on take", 32'({in_ready, out_valid, busy}), 32'b100);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("t4 accept after idle", 32'({in_ready, busy}), 32'b01);
      wait_done(lat);
      check("t4 latency", 32'(lat), 32'd4);
      check("t4 new sum", 32'(sum), 32'h3333);
      take();
      check("t4 sum holds in idle", 32'(sum), 32'h3333);

      // Asynchronous reset after two RUN edges
      start_op(16'h0F0F, 16'h0101, 1'b0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("t5 mid-run", 32'({in_ready, out_valid, busy}), 32'b001);
      #2;
      rst_n = 1'b0;
      #1;
      check("t5 async flags", 32'({in_ready, out_valid, busy}), 32'b100);
      check("t5 async outputs", 32'({sum, cout, overflow}), 32'h0);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("t5 after release", 32'({in_ready, out_valid, busy}), 32'b100);
      run_and_check("t5 post reset", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);

      // Single-slice instance
      n_in_valid = 1'b1;
      n_a = 4'hE;
      n_b = 4'hF;
      n_cin = 1'b1;
      @(posedge clk);
      #1;
      n_in_valid = 1'b0;
      check("t6 w4 running", 32'({n_in_ready, n_out_valid, n_busy}), 32'b001);
      @(posedge clk);
      #1;
      check("t6 w4 valid after 1", 32'(n_out_valid), 32'd1);
      check("t6 w4 result", 32'({n_sum, n_cout, n_overflow}), 32'({4'hE, 1'b1, 1'b0}));
      n_out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_out_ready = 1'b0;
      check("t6 w4 idle", 32'({n_in_ready, n_out_valid, n_busy}), 32'b100);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
